// File: rtl/lzw_dict_pkg.sv
// Shared types and defaults for the LZW dictionary controller.
// The optional LZW_DICT_STATS_EN build uses sat_inc32 for its event counters.
package lzw_dict_pkg;

  localparam int unsigned DEFAULT_KEY_WIDTH  = 64;
  localparam int unsigned DEFAULT_HASH_WIDTH = 12;
  localparam int unsigned DEFAULT_CODE_WIDTH = 12;
  localparam int unsigned DEFAULT_FIRST_CODE = 256;

  typedef enum logic [2:0] {
    S_IDLE,
    S_HT_RD,
    S_HT_CMP,
    S_HT_WR,
    S_CT_CMP,
    S_CT_WAIT,
    S_CT_WR,
    S_RESP
  } state_t;

  typedef struct packed {
    logic                          valid;
    logic [DEFAULT_KEY_WIDTH-1:0]  key;
    logic [DEFAULT_CODE_WIDTH-1:0] code;
  } ht_entry_t;

  function automatic logic [31:0] sat_inc32(input logic [31:0] v);
    return (v == '1) ? v : v + 32'd1;
  endfunction

endpackage

// File: rtl/lzw_dict_ctrl_if.sv
// Request/response handshake between the LZW match engine and the dictionary controller.
interface lzw_dict_ctrl_if
  import lzw_dict_pkg::*;
#(
  parameter int unsigned KEY_WIDTH  = DEFAULT_KEY_WIDTH,
  parameter int unsigned HASH_WIDTH = DEFAULT_HASH_WIDTH,
  parameter int unsigned CODE_WIDTH = DEFAULT_CODE_WIDTH
) ();

  logic                  req_valid;
  logic                  req_ready;
  logic [KEY_WIDTH-1:0]  req_key;
  logic [HASH_WIDTH-1:0] req_hash;
  logic                  resp_valid;
  logic                  resp_ready;
  logic                  resp_hit;
  logic [CODE_WIDTH-1:0] resp_code;
  logic                  resp_ins;
  logic                  resp_ovf;

  modport master (
    output req_valid, req_key, req_hash, resp_ready,
    input  req_ready, resp_valid, resp_hit, resp_code, resp_ins, resp_ovf
  );

  modport slave (
    input  req_valid, req_key, req_hash, resp_ready,
    output req_ready, resp_valid, resp_hit, resp_code, resp_ins, resp_ovf
  );

endinterface

// File: rtl/lzw_code_alloc.sv
// Next-code allocator: counts up from FIRST_CODE, saturates at the top code and flags dict_full.
module lzw_code_alloc #(
  parameter int unsigned CODE_WIDTH = 12,
  parameter int unsigned FIRST_CODE = 256
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  inc,
  output logic [CODE_WIDTH-1:0] next_code,
  output logic                  dict_full
);

  // Allocating the all-ones code sets dict_full instead of wrapping the counter.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      next_code <= CODE_WIDTH'(FIRST_CODE);
      dict_full <= 1'b0;
    end else if (inc && !dict_full) begin
      if (next_code == '1) begin
        dict_full <= 1'b1;
      end else begin
        next_code <= next_code + 1'b1;
      end
    end
  end

endmodule

// File: rtl/lzw_dict_ctrl.sv
// LZW dictionary lookup/insert sequencer over the primary hash table and conflict table.
// Optional per-outcome event counters are built when LZW_DICT_STATS_EN is defined.
module lzw_dict_ctrl
  import lzw_dict_pkg::*;
#(
  parameter int unsigned KEY_WIDTH  = DEFAULT_KEY_WIDTH,
  parameter int unsigned HASH_WIDTH = DEFAULT_HASH_WIDTH,
  parameter int unsigned CODE_WIDTH = DEFAULT_CODE_WIDTH,
  parameter int unsigned FIRST_CODE = DEFAULT_FIRST_CODE
) (
  input  logic                            clk,
  input  logic                            rst,
  lzw_dict_ctrl_if.slave                  bus,
  output logic                            ht_rd,
  output logic                            ht_we,
  output logic [HASH_WIDTH-1:0]           ht_addr,
  output logic [KEY_WIDTH+CODE_WIDTH:0]   ht_wdata,
  input  logic [KEY_WIDTH+CODE_WIDTH:0]   ht_rdata,
  output logic                            ct_cs,
  output logic                            ct_we,
  output logic [KEY_WIDTH-1:0]            ct_data,
  output logic [HASH_WIDTH-1:0]           ct_code_in,
  input  logic                            ct_match,
  input  logic [HASH_WIDTH-1:0]           ct_code_out,
  input  logic                            ct_full,
  output logic                            dict_full
`ifdef LZW_DICT_STATS_EN
  ,
  output logic [31:0]                     stat_hits,
  output logic [31:0]                     stat_misses,
  output logic [31:0]                     stat_collisions,
  output logic [31:0]                     stat_overflows
`endif
);

  state_t                state_q, state_d;
  logic [KEY_WIDTH-1:0]  key_q, key_d;
  logic [HASH_WIDTH-1:0] hash_q, hash_d;
  logic                  hit_q, hit_d, ins_q, ins_d, ovf_q, ovf_d;
  logic [CODE_WIDTH-1:0] code_q, code_d;
  logic                  alloc_inc;
  logic [CODE_WIDTH-1:0] next_code;
  logic                  rd_valid;
  logic [KEY_WIDTH-1:0]  rd_key;
  logic [CODE_WIDTH-1:0] rd_code;

  assign {rd_valid, rd_key, rd_code} = ht_rdata;

  lzw_code_alloc #(
    .CODE_WIDTH (CODE_WIDTH),
    .FIRST_CODE (FIRST_CODE)
  ) u_alloc (
    .clk       (clk),
    .rst       (rst),
    .inc       (alloc_inc),
    .next_code (next_code),
    .dict_full (dict_full)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= S_IDLE;
      key_q   <= '0;
      hash_q  <= '0;
      hit_q   <= 1'b0;
      ins_q   <= 1'b0;
      ovf_q   <= 1'b0;
      code_q  <= '0;
    end else begin
      state_q <= state_d;
      key_q   <= key_d;
      hash_q  <= hash_d;
      hit_q   <= hit_d;
      ins_q   <= ins_d;
      ovf_q   <= ovf_d;
      code_q  <= code_d;
    end
  end

  always_comb begin
    state_d       = state_q;
    key_d         = key_q;
    hash_d        = hash_q;
    hit_d         = hit_q;
    ins_d         = ins_q;
    ovf_d         = ovf_q;
    code_d        = code_q;
    bus.req_ready = 1'b0;
    bus.resp_valid = 1'b0;
    ht_rd         = 1'b0;
    ht_we         = 1'b0;
    ht_addr       = hash_q;
    ht_wdata      = '0;
    ct_cs         = 1'b0;
    ct_we         = 1'b0;
    ct_data       = key_q;
    ct_code_in    = '0;
    alloc_inc     = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        bus.req_ready = 1'b1;
        if (bus.req_valid) begin
          key_d   = bus.req_key;
          hash_d  = bus.req_hash;
          hit_d   = 1'b0;
          ins_d   = 1'b0;
          ovf_d   = 1'b0;
          code_d  = '0;
          state_d = S_HT_RD;
        end
      end
      S_HT_RD: begin
        ht_rd   = 1'b1;
        state_d = S_HT_CMP;
      end
      S_HT_CMP: begin
        if (rd_valid && rd_key == key_q) begin
          hit_d   = 1'b1;
          code_d  = rd_code;
          state_d = S_RESP;
        end else if (!rd_valid) begin
          if (!dict_full) begin
            state_d = S_HT_WR;
          end else begin
            ovf_d   = 1'b1;
            state_d = S_RESP;
          end
        end else begin
          state_d = S_CT_CMP;
        end
      end
      S_HT_WR: begin
        ht_we     = 1'b1;
        ht_wdata  = {1'b1, key_q, next_code};
        alloc_inc = 1'b1;
        ins_d     = 1'b1;
        code_d    = next_code;
        state_d   = S_RESP;
      end
      S_CT_CMP: begin
        ct_cs = 1'b1;
        if (ct_match) begin
          state_d = S_CT_WAIT;
        end else if (!ct_full && !dict_full) begin
          state_d = S_CT_WR;
        end else begin
          ovf_d   = 1'b1;
          state_d = S_RESP;
        end
      end
      S_CT_WAIT: begin
        // The conflict table's read data is registered, so the code arrives one cycle after CT_CMP.
        ct_cs   = 1'b1;
        hit_d   = 1'b1;
        code_d  = CODE_WIDTH'(ct_code_out);
        state_d = S_RESP;
      end
      S_CT_WR: begin
        ct_cs      = 1'b1;
        ct_we      = 1'b1;
        ct_code_in = HASH_WIDTH'(next_code);
        alloc_inc  = 1'b1;
        ins_d      = 1'b1;
        code_d     = next_code;
        state_d    = S_RESP;
      end
      S_RESP: begin
        bus.resp_valid = 1'b1;
        if (bus.resp_ready) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign bus.resp_hit  = hit_q;
  assign bus.resp_code = code_q;
  assign bus.resp_ins  = ins_q;
  assign bus.resp_ovf  = ovf_q;

`ifdef LZW_DICT_STATS_EN
  logic enter_resp, enter_ct;
  assign enter_resp = (state_d == S_RESP) && (state_q != S_RESP);
  assign enter_ct   = (state_d == S_CT_CMP) && (state_q != S_CT_CMP);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      stat_hits       <= '0;
      stat_misses     <= '0;
      stat_collisions <= '0;
      stat_overflows  <= '0;
    end else begin
      if (enter_resp && hit_d)  stat_hits       <= sat_inc32(stat_hits);
      if (enter_resp && !hit_d) stat_misses     <= sat_inc32(stat_misses);
      if (enter_ct)             stat_collisions <= sat_inc32(stat_collisions);
      if (enter_resp && ovf_d)  stat_overflows  <= sat_inc32(stat_overflows);
    end
  end
`endif

endmodule

// File: tb/tb_lzw_dict_ctrl.sv
// Scoreboard bench for lzw_dict_ctrl with behavioural hash-table and conflict-table models.
module tb_lzw_dict_ctrl;
  import lzw_dict_pkg::*;

  localparam int KW = 64;
  localparam int HW = 12;
  localparam int CW = 12;
  localparam int EW = 1 + KW + CW;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  lzw_dict_ctrl_if #(.KEY_WIDTH(KW), .HASH_WIDTH(HW), .CODE_WIDTH(CW)) bus ();

  logic          ht_rd, ht_we;
  logic [HW-1:0] ht_addr;
  logic [EW-1:0] ht_wdata, ht_rdata;
  logic          ct_cs, ct_we, ct_match, ct_full;
  logic [KW-1:0] ct_data;
  logic [HW-1:0] ct_code_in, ct_code_out;
  logic          dict_full;
`ifdef LZW_DICT_STATS_EN
  logic [31:0]   stat_hits, stat_misses, stat_collisions, stat_overflows;
`endif

  lzw_dict_ctrl #(
    .KEY_WIDTH (KW), .HASH_WIDTH (HW), .CODE_WIDTH (CW), .FIRST_CODE (256)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .bus         (bus.slave),
    .ht_rd       (ht_rd),
    .ht_we       (ht_we),
    .ht_addr     (ht_addr),
    .ht_wdata    (ht_wdata),
    .ht_rdata    (ht_rdata),
    .ct_cs       (ct_cs),
    .ct_we       (ct_we),
    .ct_data     (ct_data),
    .ct_code_in  (ct_code_in),
    .ct_match    (ct_match),
    .ct_code_out (ct_code_out),
    .ct_full     (ct_full),
    .dict_full   (dict_full)
`ifdef LZW_DICT_STATS_EN
    ,
    .stat_hits       (stat_hits),
    .stat_misses     (stat_misses),
    .stat_collisions (stat_collisions),
    .stat_overflows  (stat_overflows)
`endif
  );

  // Hash table memory: one-cycle read latency.
  bit [EW-1:0] ht_mem [4096];
  always @(posedge clk) begin
    if (ht_we) ht_mem[ht_addr] <= ht_wdata;
    if (ht_rd) ht_rdata <= ht_mem[ht_addr];
  end

  // Conflict table: combinational match, registered code read.
  bit [KW-1:0] ctm_key  [8];
  bit [HW-1:0] ctm_code [8];
  int          ctm_cnt = 0;
  logic [HW-1:0] ctm_hit_code;
  logic        ct_full_force;
  assign ct_full = ct_full_force || (ctm_cnt >= 8);

  always_comb begin
    ct_match     = 1'b0;
    ctm_hit_code = '0;
    for (int i = 0; i < 8; i++) begin
      if (i < ctm_cnt && ctm_key[i] == ct_data) begin
        ct_match     = 1'b1;
        ctm_hit_code = ctm_code[i];
      end
    end
  end

  always @(posedge clk) begin
    if (ct_cs && ct_we && ctm_cnt < 8) begin
      ctm_key[ctm_cnt]  <= ct_data;
      ctm_code[ctm_cnt] <= ct_code_in;
      ctm_cnt           <= ctm_cnt + 1;
    end
    if (ct_cs && !ct_we) ct_code_out <= ctm_hit_code;
  end

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic          hit;
    logic [CW-1:0] code;
    logic          ins;
    logic          ovf;
    int            lat;
    logic          ht_w;
    logic [EW-1:0] wdata;
    logic [HW-1:0] haddr;
    logic          ct_w;
    logic [HW-1:0] cin;
    logic          dfull;
  } exp_t;

  exp_t sbq[$];
  int   n_vec = 0;
  int   n_err = 0;

  function automatic exp_t mk(input bit hit, input int code, input bit ins, input bit ovf,
                              input int lat, input bit htw, input logic [KW-1:0] key,
                              input int haddr, input bit ctw, input bit dfull);
    exp_t      e;
    ht_entry_t ent;
    ent.valid = 1'b1;
    ent.key   = key;
    ent.code  = CW'(code);
    e.hit   = hit;
    e.code  = CW'(code);
    e.ins   = ins;
    e.ovf   = ovf;
    e.lat   = lat;
    e.ht_w  = htw;
    e.wdata = ent;
    e.haddr = HW'(haddr);
    e.ct_w  = ctw;
    e.cin   = HW'(code);
    e.dfull = dfull;
    return e;
  endfunction

  task automatic chk(input string nm, input logic [127:0] got, input logic [127:0] want);
    n_vec++;
    if (got !== want) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, got, want, $time);
    end
  endtask

  // Monitor: all comparisons happen here, sampled on the falling edge.
  int            t_acc = 0;
  int            req_wait = 0;
  bit            in_txn = 0, first_valid = 0, saw_ht_we = 0, saw_ct_we = 0;
  logic [EW-1:0] got_wdata;
  logic [HW-1:0] got_haddr, got_cin;
  exp_t          e;

  always @(negedge clk) begin
    if (!rst) begin
      chk("rst_req_ready", bus.req_ready, 1);
      chk("rst_strobes", {ht_rd, ht_we, ct_cs, ct_we}, 0);
      chk("rst_resp_valid", bus.resp_valid, 0);
      chk("rst_dict_full", dict_full, 0);
      in_txn   = 0;
      req_wait = 0;
    end else begin
      if (bus.req_valid && !bus.req_ready) begin
        req_wait++;
        if (req_wait == 60) chk("req_accept_timeout", bus.req_ready, 1);
      end
      if (bus.req_valid && bus.req_ready) begin
        in_txn = 1; first_valid = 1; t_acc = cyc;
        saw_ht_we = 0; saw_ct_we = 0; req_wait = 0;
      end
      if (ht_we) begin saw_ht_we = 1; got_wdata = ht_wdata; got_haddr = ht_addr; end
      if (ct_cs && ct_we) begin saw_ct_we = 1; got_cin = ct_code_in; end
      if (bus.resp_valid) begin
        if (!in_txn || sbq.size() == 0) begin
          chk("resp_without_req", bus.resp_valid, 0);
        end else begin
          e = sbq[0];
          if (first_valid) begin
            chk("latency", cyc - t_acc, e.lat);
            first_valid = 0;
          end
          if (bus.resp_ready) begin
            chk("resp_hit", bus.resp_hit, e.hit);
            chk("resp_code", bus.resp_code, e.code);
            chk("resp_ins", bus.resp_ins, e.ins);
            chk("resp_ovf", bus.resp_ovf, e.ovf);
            chk("dict_full", dict_full, e.dfull);
            chk("req_ready_in_resp", bus.req_ready, 0);
            chk("ht_we_seen", saw_ht_we, e.ht_w);
            if (e.ht_w) begin
              chk("ht_wdata", got_wdata, e.wdata);
              chk("ht_addr", got_haddr, e.haddr);
            end
            chk("ct_we_seen", saw_ct_we, e.ct_w);
            if (e.ct_w) chk("ct_code_in", got_cin, e.cin);
            void'(sbq.pop_front());
            in_txn = 0;
          end
        end
      end
      if (in_txn && (cyc - t_acc) > 40) begin
        chk("resp_timeout", bus.resp_valid, 1);
        in_txn = 0;
        if (sbq.size() != 0) void'(sbq.pop_front());
      end
    end
  end

  // Driver: entered and left just after a rising edge.
  task automatic issue(input logic [KW-1:0] k, input logic [HW-1:0] h, input int hold, input exp_t ex);
    int n;
    sbq.push_back(ex);
    bus.req_valid = 1'b1;
    bus.req_key   = k;
    bus.req_hash  = h;
    if (hold > 0) bus.resp_ready = 1'b0;
    n = 0;
    while (!bus.req_ready && n < 80) begin @(posedge clk); #1; n++; end
    @(posedge clk); #1;
    bus.req_valid = 1'b0;
    if (hold > 0) begin
      n = 0;
      while (!bus.resp_valid && n < 80) begin @(posedge clk); #1; n++; end
      repeat (hold) @(posedge clk);
      #1 bus.resp_ready = 1'b1;
    end
    n = 0;
    while (sbq.size() != 0 && n < 80) begin @(posedge clk); #1; n++; end
    @(posedge clk); #1;
  endtask

  localparam logic [KW-1:0] KEY1 = 64'h41_0042;
  localparam logic [KW-1:0] KEY2 = 64'h43_0100;
  localparam logic [KW-1:0] KEY3 = 64'h44_0200;

  logic [HW-1:0] fh;

  initial begin
    bus.req_valid  = 1'b0;
    bus.req_key    = '0;
    bus.req_hash   = '0;
    bus.resp_ready = 1'b1;
    ct_full_force  = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk); #1;

    // Empty table: insert into the hash table.
    issue(KEY1, 12'h123, 0, mk(0, 256, 1, 0, 4, 1, KEY1, 'h123, 0, 0));
    // Same key now present: hit, with the response held for a few cycles.
    issue(KEY1, 12'h123, 3, mk(1, 256, 0, 0, 3, 0, KEY1, 'h123, 0, 0));
    // Collision on the same hash: conflict-table insert, then conflict-table hit.
    issue(KEY2, 12'h123, 0, mk(0, 257, 1, 0, 5, 0, KEY2, 'h123, 1, 0));
    issue(KEY2, 12'h123, 0, mk(1, 257, 0, 0, 5, 0, KEY2, 'h123, 0, 0));
    // Conflict table full: overflow, no allocation.
    ct_full_force = 1'b1;
    issue(KEY3, 12'h123, 0, mk(0, 0, 0, 1, 4, 0, KEY3, 'h123, 0, 0));
    ct_full_force = 1'b0;

    // Fill codes 258..4095; the last insert sets dict_full.
    for (int i = 0; i < 3838; i++) begin
      fh = (i < 'h123) ? HW'(i) : HW'(i + 1);
      issue(64'h1_0000_0000 + KW'(i), fh, 0,
            mk(0, 258 + i, 1, 0, 4, 1, 64'h1_0000_0000 + KW'(i), int'(fh), 0, (i == 3837)));
    end

    // Codes exhausted: miss into an empty slot overflows without writing.
    issue(64'hDEAD, 12'hFFF, 0, mk(0, 0, 0, 1, 3, 0, 64'hDEAD, 'hFFF, 0, 1));

    // Reset during CT_WAIT of a conflict-table hit; the response must never appear.
    bus.req_valid = 1'b1;
    bus.req_key   = KEY2;
    bus.req_hash  = 12'h123;
    @(posedge clk); #1;
    bus.req_valid = 1'b0;
    repeat (3) @(posedge clk);
    #2 rst = 1'b0;
    @(negedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;

    // After reset the allocator restarts at 256 and dict_full is clear.
    issue(64'hBEEF, 12'hFFF, 0, mk(0, 256, 1, 0, 4, 1, 64'hBEEF, 'hFFF, 0, 0));
    issue(KEY2, 12'h123, 0, mk(1, 257, 0, 0, 5, 0, KEY2, 'h123, 0, 0));

    repeat (5) @(posedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not complete (vectors %0d, miscompares %0d)", n_vec, n_err);
    $fatal(1, "watchdog expired");
  end

endmodule
